stream_in: RTL and testbench

//  Input deserializer feeding the AES core. Collects four 32-bit bus words into
//  one 128-bit block plus its type bit, then presents the block with a one-cycle

---
 rtl/stream_in.sv | 138 +++++++++++++
 tb/tb_stream_in.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_in.sv
`default_nettype none
// ============================================================================
// Module      : stream_in
// Description : Input deserializer for the AES core. Packs four 32-bit words
//               (first word -> bits [127:96]) plus a type bit into a 128-bit
//               block and emits it with a one-cycle vout pulse. A word whose
//               type differs from the block in progress drops the partial
//               block, pulses err and starts a new block.
//               Optional feature macro: STREAM_IN_TIMEOUT_EN -- discards a
//               partial block after TIMEOUT consecutive idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_in #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vin,
    input  logic         tin,
    input  logic [31:0]  din,
    output logic         vout,
    output logic         tout,
    output logic [127:0] dout,
    output logic         err
);

    // Reject an out-of-range timeout at elaboration time.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("stream_in: TIMEOUT must be in 1..65535");
    end

    // Word counter: 0 means no partial block is held.
    logic [1:0]   cnt_q, cnt_d;
    // Only the upper three words are ever stored; the fourth comes from din.
    logic [127:32] acc_q, acc_d;
    logic         btype_q, btype_d;
    logic         vout_q, vout_d;
    logic         tout_q, tout_d;
    logic [127:0] dout_q, dout_d;
    logic         err_q, err_d;

`ifdef STREAM_IN_TIMEOUT_EN
    localparam logic [15:0] C_IDLE_LAST = 16'(TIMEOUT - 1);
    logic [15:0]  idle_q, idle_d;
`endif

    // Next-state logic: word capture, block completion, type check, timeout.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        btype_d = btype_q;
        vout_d  = 1'b0;
        tout_d  = tout_q;
        dout_d  = dout_q;
        err_d   = 1'b0;
`ifdef STREAM_IN_TIMEOUT_EN
        idle_d  = 16'd0;
`endif

        if (vin) begin
            if (cnt_q == 2'd0 || tin != btype_q) begin
                // Start a new block; a type change drops the old partial one.
                err_d          = (cnt_q != 2'd0);
                acc_d[127:96]  = din;
                btype_d        = tin;
                cnt_d          = 2'd1;
            end else begin
                case (cnt_q)
                    2'd1: begin
                        acc_d[95:64] = din;
                        cnt_d        = 2'd2;
                    end
                    2'd2: begin
                        acc_d[63:32] = din;
                        cnt_d        = 2'd3;
                    end
                    default: begin
                        dout_d = {acc_q[127:32], din};
                        tout_d = btype_q;
                        vout_d = 1'b1;
                        cnt_d  = 2'd0;
                    end
                endcase
            end
        end
`ifdef STREAM_IN_TIMEOUT_EN
        else if (cnt_q != 2'd0) begin
            // Idle with a partial block held: count toward expiry.
            if (idle_q == C_IDLE_LAST) begin
                cnt_d  = 2'd0;
                err_d  = 1'b1;
                idle_d = 16'd0;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end
`endif
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            acc_q   <= '0;
            btype_q <= 1'b0;
            vout_q  <= 1'b0;
            tout_q  <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            btype_q <= btype_d;
            vout_q  <= vout_d;
            tout_q  <= tout_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

`ifdef STREAM_IN_TIMEOUT_EN
    // Idle cycle counter for the partial-block timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= 16'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign vout = vout_q;
    assign tout = tout_q;
    assign dout = dout_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_in.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_in
// Description : Directed self-checking bench for stream_in. Covers reset,
//               block assembly, gaps, type mismatch, back-to-back blocks,
//               asynchronous mid-block reset and (with STREAM_IN_TIMEOUT_EN)
//               the idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_in;

    logic         clk = 1'b0;
    logic         rst;
    logic         vin;
    logic         tin;
    logic [31:0]  din;
    logic         vout;
    logic         tout;
    logic [127:0] dout;
    logic         err;

    int errors = 0;
    int checks = 0;
    int vout_cnt = 0;
    int err_cnt  = 0;
    int v0, e0;

    stream_in #(.TIMEOUT(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .vin  (vin),
        .tin  (tin),
        .din  (din),
        .vout (vout),
        .tout (tout),
        .dout (dout),
        .err  (err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (vout) vout_cnt++;
        if (err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one word for one clock, then sample 1 ns after the edge.
    task automatic word(input logic t, input logic [31:0] d);
        vin = 1'b1; tin = t; din = d;
        @(posedge clk); #1;
        vin = 1'b0;
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0; tin = 1'b0; din = 32'h0;
        #12;
        chk("rst_vout", {127'd0, vout}, 128'd0);
        chk("rst_dout", dout, 128'd0);
        chk("rst_err",  {127'd0, err}, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic data block
        word(1'b0, 32'h00112233);
        word(1'b0, 32'h44556677);
        word(1'b0, 32'h8899AABB);
        chk("t2_vout_early", {127'd0, vout}, 128'd0);
        word(1'b0, 32'hCCDDEEFF);
        chk("t2_vout", {127'd0, vout}, 128'd1);
        chk("t2_tout", {127'd0, tout}, 128'd0);
        chk("t2_dout", dout, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        idle(1);
        chk("t2_vout_pulse", {127'd0, vout}, 128'd0);

        // Key block with gaps 0,3,7
        v0 = vout_cnt; e0 = err_cnt;
        word(1'b1, 32'h01010101);
        word(1'b1, 32'h02020202);
        idle(3);
        word(1'b1, 32'h03030303);
        idle(7);
        word(1'b1, 32'h04040404);
        chk("t3_vout", {127'd0, vout}, 128'd1);
        chk("t3_tout", {127'd0, tout}, 128'd1);
        chk("t3_dout", dout, 128'h01010101_02020202_03030303_04040404);
        idle(1);
        chk("t3_vout_count", 128'(vout_cnt - v0), 128'd1);
        chk("t3_err_count",  128'(err_cnt - e0), 128'd0);

        // Type mismatch restarts the block
        e0 = err_cnt;
        word(1'b0, 32'hAAAA0000);
        word(1'b0, 32'hBBBB0000);
        word(1'b1, 32'hDEADBEEF);
        chk("t4_err", {127'd0, err}, 128'd1);
        chk("t4_vout", {127'd0, vout}, 128'd0);
        idle(1);
        chk("t4_err_pulse", {127'd0, err}, 128'd0);
        word(1'b1, 32'h11111111);
        word(1'b1, 32'h22222222);
        word(1'b1, 32'h33333333);
        chk("t4_vout", {127'd0, vout}, 128'd1);
        chk("t4_tout", {127'd0, tout}, 128'd1);
        chk("t4_dout", dout, 128'hDEADBEEF_11111111_22222222_33333333);
        idle(1);
        chk("t4_err_count", 128'(err_cnt - e0), 128'd1);

        // Back-to-back blocks
        v0 = vout_cnt;
        word(1'b0, 32'hA0000001);
        word(1'b0, 32'hA0000002);
        word(1'b0, 32'hA0000003);
        word(1'b0, 32'hA0000004);
        chk("t5_vout1", {127'd0, vout}, 128'd1);
        chk("t5_dout1", dout, 128'hA0000001_A0000002_A0000003_A0000004);
        word(1'b0, 32'hB0000001);
        chk("t5_vout_gap", {127'd0, vout}, 128'd0);
        word(1'b0, 32'hB0000002);
        word(1'b0, 32'hB0000003);
        chk("t5_dout_hold", dout, 128'hA0000001_A0000002_A0000003_A0000004);
        word(1'b0, 32'hB0000004);
        chk("t5_vout2", {127'd0, vout}, 128'd1);
        chk("t5_dout2", dout, 128'hB0000001_B0000002_B0000003_B0000004);
        idle(1);
        chk("t5_vout_count", 128'(vout_cnt - v0), 128'd2);

        // Asynchronous reset mid-cycle while vout is high
        word(1'b1, 32'hC0000001);
        word(1'b1, 32'hC0000002);
        word(1'b1, 32'hC0000003);
        word(1'b1, 32'hC0000004);
        chk("t1_pre_vout", {127'd0, vout}, 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_vout", {127'd0, vout}, 128'd0);
        chk("t1_async_tout", {127'd0, tout}, 128'd0);
        chk("t1_async_dout", dout, 128'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a block drops it silently
        e0 = err_cnt;
        word(1'b1, 32'hE0000001);
        word(1'b1, 32'hE0000002);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        word(1'b0, 32'hF0000001);
        word(1'b0, 32'hF0000002);
        word(1'b0, 32'hF0000003);
        word(1'b0, 32'hF0000004);
        chk("rstmid_vout", {127'd0, vout}, 128'd1);
        chk("rstmid_dout", dout, 128'hF0000001_F0000002_F0000003_F0000004);
        idle(1);
        chk("rstmid_err_count", 128'(err_cnt - e0), 128'd0);

`ifdef STREAM_IN_TIMEOUT_EN
        // Timeout expiry after 16 idle cycles
        e0 = err_cnt;
        word(1'b0, 32'h12345678);
        idle(15);
        chk("t6_no_err_15", 128'(err_cnt - e0), 128'd0);
        chk("t6_err_15", {127'd0, err}, 128'd0);
        idle(1);
        chk("t6_err", {127'd0, err}, 128'd1);
        chk("t6_cnt", {126'd0, dut.cnt_q}, 128'd0);
        idle(1);
        chk("t6_err_pulse", {127'd0, err}, 128'd0);
        // A word in the would-be expiry cycle is accepted
        e0 = err_cnt;
        word(1'b0, 32'h12345678);
        idle(15);
        word(1'b0, 32'h9ABCDEF0);
        chk("t6b_err", {127'd0, err}, 128'd0);
        chk("t6b_cnt", {126'd0, dut.cnt_q}, 128'd2);
        idle(1);
        chk("t6b_err_count", 128'(err_cnt - e0), 128'd0);
`else
        // Without the timeout a long gap never discards the block
        e0 = err_cnt;
        word(1'b1, 32'h5A5A0001);
        idle(20);
        word(1'b1, 32'h5A5A0002);
        word(1'b1, 32'h5A5A0003);
        word(1'b1, 32'h5A5A0004);
        chk("gap_vout", {127'd0, vout}, 128'd1);
        chk("gap_dout", dout, 128'h5A5A0001_5A5A0002_5A5A0003_5A5A0004);
        idle(1);
        chk("gap_err_count", 128'(err_cnt - e0), 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
